// File: rtl/count_step_checker.sv
// Step monitor for an up/down counter: checks every clock step is exactly +/-1 in the
// commanded direction, counts wraps and errors, and tracks IDLE/TRACK/FAULT status.
// Optional last-error history registers are built when CHK_HISTORY_EN is defined.
module count_step_checker #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8,
  parameter int FAULT_ERRS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cnt_rst,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  up_down,
  output logic                  locked,
  output logic                  fault,
  output logic                  step_err,
  output logic                  wrap_up,
  output logic                  wrap_down,
  output logic                  dir_change,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      err_expected,
  output logic [WIDTH-1:0]      err_actual
);

  localparam int CW = $clog2(FAULT_ERRS + 1);
  localparam logic [CW-1:0] FAULT_LIM = CW'(FAULT_ERRS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                  r_state;
  logic [WIDTH-1:0]        r_prev;
  logic                    r_dir_q;
  logic [CW-1:0]           r_consec;
  logic [ERR_CNT_W-1:0]    r_err_count;
  logic [WRAP_CNT_W-1:0]   r_wrap_count;
  logic                    r_locked;
  logic                    r_fault;
  logic                    r_step_err;
  logic                    r_wrap_up;
  logic                    r_wrap_down;
  logic                    r_dir_change;

  logic [WIDTH-1:0]        w_expected;
  logic                    w_mismatch;
  logic                    w_wrap_up;
  logic                    w_wrap_down;
  logic                    w_hit_limit;
  logic                    w_comparing;

  // dir_q is the direction the counter applied to produce the current count_in.
  assign w_expected  = r_dir_q ? (r_prev + WIDTH'(1)) : (r_prev - WIDTH'(1));
  assign w_mismatch  = (count_in != w_expected);
  assign w_wrap_up   =  r_dir_q && (r_prev == '1) && (count_in == '0);
  assign w_wrap_down = !r_dir_q && (r_prev == '0) && (count_in == '1);
  assign w_hit_limit = (r_consec >= FAULT_LIM - CW'(1));
  assign w_comparing = !clr && !cnt_rst && (r_state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_dir_q      <= 1'b0;
      r_consec     <= '0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_step_err   <= 1'b0;
      r_wrap_up    <= 1'b0;
      r_wrap_down  <= 1'b0;
      r_dir_change <= 1'b0;
    end else begin
      r_prev       <= count_in;
      r_dir_q      <= up_down;
      r_dir_change <= (up_down != r_dir_q);
      r_step_err   <= 1'b0;
      r_wrap_up    <= 1'b0;
      r_wrap_down  <= 1'b0;

      if (clr) begin
        r_state      <= IDLE;
        r_locked     <= 1'b0;
        r_fault      <= 1'b0;
        r_consec     <= '0;
        r_err_count  <= '0;
        r_wrap_count <= '0;
      end else if (cnt_rst) begin
        // A counter reset breaks the step chain; statistics survive it.
        r_state  <= IDLE;
        r_locked <= 1'b0;
        r_fault  <= 1'b0;
        r_consec <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= TRACK;
            r_locked <= 1'b1;
          end
          TRACK: begin
            if (w_mismatch) begin
              r_step_err <= 1'b1;
              if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
              if (r_consec != FAULT_LIM) r_consec <= r_consec + 1'b1;
              if (w_hit_limit) begin
                r_state  <= FAULT;
                r_locked <= 1'b0;
                r_fault  <= 1'b1;
              end
            end else begin
              r_consec    <= '0;
              r_wrap_up   <= w_wrap_up;
              r_wrap_down <= w_wrap_down;
              if ((w_wrap_up || w_wrap_down) && (r_wrap_count != '1))
                r_wrap_count <= r_wrap_count + 1'b1;
            end
          end
          FAULT: begin
            if (w_mismatch) begin
              r_step_err <= 1'b1;
              if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
              if (r_consec != FAULT_LIM) r_consec <= r_consec + 1'b1;
            end else begin
              r_consec <= '0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CHK_HISTORY_EN
  logic [WIDTH-1:0] r_err_expected;
  logic [WIDTH-1:0] r_err_actual;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_expected <= '0;
      r_err_actual   <= '0;
    end else if (clr) begin
      r_err_expected <= '0;
      r_err_actual   <= '0;
    end else if (w_comparing && w_mismatch) begin
      r_err_expected <= w_expected;
      r_err_actual   <= count_in;
    end
  end

  assign err_expected = r_err_expected;
  assign err_actual   = r_err_actual;
`else
  logic w_unused;
  assign w_unused     = w_comparing;
  assign err_expected = '0;
  assign err_actual   = '0;
`endif

  assign locked     = r_locked;
  assign fault      = r_fault;
  assign step_err   = r_step_err;
  assign wrap_up    = r_wrap_up;
  assign wrap_down  = r_wrap_down;
  assign dir_change = r_dir_change;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;

endmodule
